tse_init_sequencer: RTL and testbench
=====================================

Name: tse_init_sequencer

Overview:
- Command-table sequencer that brings up the TSE MAC after reset.
- Steps through a ROM of init commands: register writes, masked-compare polls and fixed delays.
- Issues each command as a single request/acknowledge transaction to the downstream Avalon-MM init master, which drives the MAC control port.
- Reports done/error status to the board-level reset/link controller.

Parameters:
- ROM_DEPTH, 32, number of command entries; index width = $clog2(ROM_DEPTH).
- POLL_MAX, 1000, maximum read attempts per POLL command before error.
- TIMEOUT_CYC, 4096, maximum cycles from request assertion to action_done.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins sequence at entry 0; ignored unless IDLE, DONE or ERROR
- busy  out  1  high from start until DONE/ERROR
- done  out  1  sticky high after END executed; cleared by start
- error  out  1  sticky high on timeout or poll exhaustion; cleared by start
- err_index  out  idx_w  ROM index of failing command; 0 when no error
- err_code  out  2  0 none, 1 bus timeout, 2 poll exhausted
- wr_rq  out  1  write request, held until action_done
- rd_rq  out  1  read request, held until action_done
- wr_adr  out  32  write address (bits [9:0] used, [31:10] zero)
- rd_adr  out  32  read address (bits [9:0] used, [31:10] zero)
- wr_data  out  32  write data
- action_done  in  1  combinational ack from downstream; transfer complete this cycle
- rd_valid  in  1  read data valid (coincides with action_done on reads)
- rd_data  in  32  read data, sampled when rd_valid=1

Behaviour:
- Reset: state IDLE, all outputs 0, index 0, counters 0.
- ROM entry (76 bits): op[75:74], adr[73:64], data[63:32], mask[31:0].
- Ops:
  - OP_WR=0: write data to adr.
  - OP_POLL=1: read adr until (rd_data & mask) == (data & mask).
  - OP_DELAY=2: idle for data[15:0] cycles.
  - OP_END=3: finish the sequence.
- ROM is combinational (index -> entry). Entry is latched into a command register in FETCH.
- FSM states: IDLE, FETCH, WR_REQ, RD_REQ, CHECK, DELAY, DONE, ERROR.
- IDLE/DONE/ERROR + start -> FETCH. On start: index=0, done=0, error=0, err_code=0, err_index=0, busy=1.
- FETCH (1 cycle): latch entry, then dispatch by op:
  - WR -> WR_REQ, with wr_rq=1 registered.
  - POLL -> RD_REQ, with rd_rq=1 registered.
  - DELAY -> DELAY; a count of 0 behaves as 1 cycle.
  - END -> DONE.
- Request handshake:
  - rq, adr and data are registered and stay stable while the request is pending.
  - On the clock edge where action_done=1, rq clears; the downstream sees rq=0 when it returns to its own IDLE, so no duplicate transfer occurs.
  - wr_rq and rd_rq are never high together.
- WR_REQ + action_done -> advance index -> FETCH.
- RD_REQ + rd_valid: rd_data is captured -> CHECK.
- CHECK:
  - Match -> advance index -> FETCH.
  - Mismatch with poll_cnt+1 < POLL_MAX -> poll_cnt++, re-issue read (RD_REQ, rd_rq=1 next cycle).
  - Otherwise -> ERROR, err_code=2.
- poll_cnt resets to 0 in FETCH.
- Timeout:
  - Counter runs while in WR_REQ/RD_REQ and clears on each new request.
  - Reaching TIMEOUT_CYC-1 with no action_done: drop rq -> ERROR, err_code=1.
  - action_done arriving on that same cycle wins (no error).
- Minimum latency per WR command: FETCH + 1 request cycle = 2 cycles when action_done returns on the first request cycle.
- Index reaching ROM_DEPTH-1 without END: the entry at ROM_DEPTH-1 is executed, then the sequence goes to DONE (no wrap).
- ERROR/DONE: busy=0, status held, err_index = index of the failing command.
- start while busy: ignored.
- RST_I mid-transaction: outputs clear asynchronously. The downstream shares the same reset, so no orphaned transfer remains.

Decomposition:
- Package tse_init_pkg holds:
  - op_t enum (OP_WR, OP_POLL, OP_DELAY, OP_END)
  - cmd_t packed struct (op, adr, data, mask)
  - err_code constants
  - TSE register offset constants (COMMAND_CONFIG, MAC_0/1, FRM_LENGTH, RX_SECTION_*, TX_SECTION_*)
- Sub-module tse_init_rom: combinational index -> cmd_t case table holding the MAC bring-up sequence. The table is:
  1. write COMMAND_CONFIG SW_RESET
  2. poll until SW_RESET clears
  3. write MAC address and FRM_LENGTH
  4. enable TX/RX
  5. END
- Sequencer FSM and counters live in tse_init_sequencer.

Test Plan:
- Write and end:
  - Stimulus: ROM {WR 0x008 = 0x0000_2003, END}; start; action_done returned 1 cycle after wr_rq rises.
  - Required: one wr_rq pulse with wr_adr=0x008 and wr_data=0x2003; done=1 and busy=0 within 5 cycles; no rd_rq.
- Poll success:
  - Stimulus: POLL adr 0x008, mask 0x2000, data 0; rd_data=0x2000 for 3 reads, then 0x0000.
  - Required: exactly 4 rd_rq transactions, then advance; error=0.
- Poll exhaustion:
  - Stimulus: POLL_MAX=4; rd_data held at 0x2000.
  - Required: 4 reads, then error=1, err_code=2, err_index = POLL entry index.
- Bus timeout:
  - Stimulus: TIMEOUT_CYC=16; action_done held low.
  - Required: wr_rq high for 16 cycles then drops; err_code=1; done=0.
- Delay and restart:
  - Stimulus: DELAY 10 between two WRs.
  - Required: 10-cycle gap with no requests; start issued after done clears done and reruns from index 0.
  - Additionally: start while busy has no effect.
- Reset mid-request:
  - Stimulus: assert RST_I while rd_rq=1.
  - Required: rd_rq, busy, done and error go 0 asynchronously; state IDLE after release.

Source files
------------

// File: rtl/tse_init_pkg.sv
// Shared types and TSE register map for the MAC bring-up sequencer.
package tse_init_pkg;

    typedef enum logic [1:0] {
        OP_WR    = 2'd0,
        OP_POLL  = 2'd1,
        OP_DELAY = 2'd2,
        OP_END   = 2'd3
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [9:0]  adr;
        logic [31:0] data;
        logic [31:0] mask;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WR_REQ, S_RD_REQ,
        S_CHECK, S_DELAY, S_DONE, S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_POLL    = 2'd2;

    localparam logic [9:0] COMMAND_CONFIG   = 10'h008;
    localparam logic [9:0] MAC_0            = 10'h00C;
    localparam logic [9:0] MAC_1            = 10'h010;
    localparam logic [9:0] FRM_LENGTH       = 10'h014;
    localparam logic [9:0] RX_SECTION_EMPTY = 10'h01C;
    localparam logic [9:0] RX_SECTION_FULL  = 10'h020;
    localparam logic [9:0] TX_SECTION_EMPTY = 10'h024;
    localparam logic [9:0] TX_SECTION_FULL  = 10'h028;

    localparam logic [31:0] CC_TX_ENA   = 32'h0000_0001;
    localparam logic [31:0] CC_RX_ENA   = 32'h0000_0002;
    localparam logic [31:0] CC_SW_RESET = 32'h0000_2000;

    function automatic cmd_t mk(op_t op, logic [9:0] adr,
                                logic [31:0] data, logic [31:0] mask);
        cmd_t c;
        c.op   = op;
        c.adr  = adr;
        c.data = data;
        c.mask = mask;
        return c;
    endfunction

endpackage

// File: rtl/tse_init_sequencer_if.sv
// Request/acknowledge link between the sequencer and the Avalon-MM init master.
interface tse_init_sequencer_if;
    logic        wr_rq;
    logic        rd_rq;
    logic [31:0] wr_adr;
    logic [31:0] rd_adr;
    logic [31:0] wr_data;
    logic        action_done;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        output wr_rq, rd_rq, wr_adr, rd_adr, wr_data,
        input  action_done, rd_valid, rd_data
    );

    modport slave (
        input  wr_rq, rd_rq, wr_adr, rd_adr, wr_data,
        output action_done, rd_valid, rd_data
    );
endinterface

// File: rtl/tse_init_rom.sv
// Combinational MAC bring-up command table; unused entries decode to END.
module tse_init_rom
    import tse_init_pkg::*;
#(
    parameter  int ROM_DEPTH = 32,
    localparam int IW        = $clog2(ROM_DEPTH)
) (
    input  logic [IW-1:0] index,
    output cmd_t          cmd
);

    always_comb begin
        cmd = mk(OP_END, 10'h000, 32'h0, 32'h0);
        case (32'(index))
            0:  cmd = mk(OP_WR,    COMMAND_CONFIG,   CC_SW_RESET,  32'h0);
            1:  cmd = mk(OP_POLL,  COMMAND_CONFIG,   32'h0,        CC_SW_RESET);
            2:  cmd = mk(OP_WR,    MAC_0,            32'h3322_1100, 32'h0);
            3:  cmd = mk(OP_WR,    MAC_1,            32'h0000_5544, 32'h0);
            4:  cmd = mk(OP_WR,    FRM_LENGTH,       32'd1518,     32'h0);
            5:  cmd = mk(OP_WR,    RX_SECTION_EMPTY, 32'd0,        32'h0);
            6:  cmd = mk(OP_WR,    RX_SECTION_FULL,  32'd16,       32'h0);
            7:  cmd = mk(OP_WR,    TX_SECTION_EMPTY, 32'd0,        32'h0);
            8:  cmd = mk(OP_WR,    TX_SECTION_FULL,  32'd16,       32'h0);
            9:  cmd = mk(OP_DELAY, 10'h000,          32'd10,       32'h0);
            10: cmd = mk(OP_WR,    COMMAND_CONFIG,   CC_TX_ENA | CC_RX_ENA, 32'h0);
            default: cmd = mk(OP_END, 10'h000, 32'h0, 32'h0);
        endcase
    end

endmodule

// File: rtl/tse_init_sequencer.sv
// Walks the init ROM, issuing writes, masked polls and delays to the MAC.
module tse_init_sequencer
    import tse_init_pkg::*;
#(
    parameter  int ROM_DEPTH   = 32,
    parameter  int POLL_MAX    = 1000,
    parameter  int TIMEOUT_CYC = 4096,
    localparam int IW          = $clog2(ROM_DEPTH)
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [IW-1:0] err_index,
    output logic [1:0]    err_code,
    tse_init_sequencer_if.master bus
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [9:0]    cmd_adr, adr_n;
    logic [31:0]   cmd_data, data_n;
    logic [31:0]   cmd_mask, mask_n;
    logic [31:0]   rdat, rdat_n;
    logic [PW-1:0] poll_cnt, poll_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic [15:0]   dly_cnt, dly_n;
    logic          wr_q, wr_n, rd_q, rd_n;
    logic          done_n, err_n;
    logic [1:0]    code_n;
    logic [IW-1:0] eidx_n;
    logic          adv, fail;
    logic [1:0]    fail_code;
    cmd_t          rom_cmd;

    tse_init_rom #(.ROM_DEPTH(ROM_DEPTH)) u_rom (
        .index (idx),
        .cmd   (rom_cmd)
    );

    assign busy        = !(state inside {S_IDLE, S_DONE, S_ERROR});
    assign bus.wr_rq   = wr_q;
    assign bus.rd_rq   = rd_q;
    assign bus.wr_adr  = {22'd0, cmd_adr};
    assign bus.rd_adr  = {22'd0, cmd_adr};
    assign bus.wr_data = cmd_data;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state     <= S_IDLE;
            idx       <= '0;
            cmd_adr   <= '0;
            cmd_data  <= '0;
            cmd_mask  <= '0;
            rdat      <= '0;
            poll_cnt  <= '0;
            tmo_cnt   <= '0;
            dly_cnt   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            err_index <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cmd_adr   <= adr_n;
            cmd_data  <= data_n;
            cmd_mask  <= mask_n;
            rdat      <= rdat_n;
            poll_cnt  <= poll_n;
            tmo_cnt   <= tmo_n;
            dly_cnt   <= dly_n;
            wr_q      <= wr_n;
            rd_q      <= rd_n;
            done      <= done_n;
            error     <= err_n;
            err_code  <= code_n;
            err_index <= eidx_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        adr_n     = cmd_adr;
        data_n    = cmd_data;
        mask_n    = cmd_mask;
        rdat_n    = rdat;
        poll_n    = poll_cnt;
        tmo_n     = tmo_cnt;
        dly_n     = dly_cnt;
        wr_n      = wr_q;
        rd_n      = rd_q;
        done_n    = done;
        err_n     = error;
        code_n    = err_code;
        eidx_n    = err_index;
        adv       = 1'b0;
        fail      = 1'b0;
        fail_code = ERR_NONE;

        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_n = S_FETCH;
                    idx_n   = '0;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                    code_n  = ERR_NONE;
                    eidx_n  = '0;
                end
            end
            S_FETCH: begin
                adr_n  = rom_cmd.adr;
                data_n = rom_cmd.data;
                mask_n = rom_cmd.mask;
                poll_n = '0;
                tmo_n  = '0;
                unique case (rom_cmd.op)
                    OP_WR: begin
                        state_n = S_WR_REQ;
                        wr_n    = 1'b1;
                    end
                    OP_POLL: begin
                        state_n = S_RD_REQ;
                        rd_n    = 1'b1;
                    end
                    OP_DELAY: begin
                        state_n = S_DELAY;
                        dly_n   = (rom_cmd.data[15:0] == 16'd0) ?
                                  16'd1 : rom_cmd.data[15:0];
                    end
                    OP_END: begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end
                endcase
            end
            S_WR_REQ: begin
                if (bus.action_done) begin
                    wr_n = 1'b0;
                    adv  = 1'b1;
                end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    wr_n      = 1'b0;
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end else begin
                    tmo_n = tmo_cnt + TW'(1);
                end
            end
            S_RD_REQ: begin
                if (bus.action_done) begin
                    rd_n    = 1'b0;
                    state_n = S_CHECK;
                    if (bus.rd_valid) rdat_n = bus.rd_data;
                end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    rd_n      = 1'b0;
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end else begin
                    tmo_n = tmo_cnt + TW'(1);
                end
            end
            S_CHECK: begin
                if (((rdat ^ cmd_data) & cmd_mask) == 32'd0) begin
                    adv = 1'b1;
                end else if (int'(poll_cnt) + 1 < POLL_MAX) begin
                    poll_n  = poll_cnt + PW'(1);
                    tmo_n   = '0;
                    rd_n    = 1'b1;
                    state_n = S_RD_REQ;
                end else begin
                    fail      = 1'b1;
                    fail_code = ERR_POLL;
                end
            end
            S_DELAY: begin
                if (dly_cnt <= 16'd1) adv = 1'b1;
                else dly_n = dly_cnt - 16'd1;
            end
        endcase

        // The last ROM slot finishes the sequence rather than wrapping to 0.
        if (adv) begin
            if (idx == IW'(ROM_DEPTH - 1)) begin
                state_n = S_DONE;
                done_n  = 1'b1;
            end else begin
                idx_n   = idx + IW'(1);
                state_n = S_FETCH;
            end
        end
        if (fail) begin
            state_n = S_ERROR;
            err_n   = 1'b1;
            code_n  = fail_code;
            eidx_n  = idx;
        end
    end

endmodule

// File: tb/tb_tse_init_sequencer.sv
// Directed bench: a behavioural init master answers requests with set latencies.
module tb_tse_init_sequencer;
    import tse_init_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy, done, error;
    logic [4:0] err_index;
    logic [1:0] err_code;

    tse_init_sequencer_if bus();

    tse_init_sequencer #(
        .ROM_DEPTH   (32),
        .POLL_MAX    (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index),
        .err_code  (err_code),
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;

    int lat, rd_lat, busy_reads;
    int cyc, wcnt, ntx, nrd, busy_cyc, wr_hi, both_hi;
    logic [31:0] tx_adr [64];
    logic [31:0] tx_dat [64];
    bit          tx_rd  [64];
    int          rise_c [64];
    int          ack_c  [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream init master model, evaluated once per cycle on the low phase.
    initial begin
        cyc = 0; wcnt = 0; ntx = 0; nrd = 0;
        busy_cyc = 0; wr_hi = 0; both_hi = 0;
        bus.action_done = 1'b0;
        bus.rd_valid    = 1'b0;
        bus.rd_data     = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.action_done = 1'b0;
            bus.rd_valid    = 1'b0;
            if (busy) busy_cyc++;
            if (bus.wr_rq) wr_hi++;
            if (bus.wr_rq && bus.rd_rq) both_hi++;
            if (rst || !(bus.wr_rq || bus.rd_rq)) begin
                wcnt = 0;
            end else begin
                if (wcnt == 0 && ntx < 64) rise_c[ntx] = cyc;
                if (wcnt >= (bus.rd_rq ? rd_lat : lat)) begin
                    bus.action_done = 1'b1;
                    if (ntx < 64) begin
                        tx_rd[ntx]  = bus.rd_rq;
                        tx_adr[ntx] = bus.rd_rq ? bus.rd_adr : bus.wr_adr;
                        tx_dat[ntx] = bus.wr_data;
                        ack_c[ntx]  = cyc;
                    end
                    ntx++;
                    if (bus.rd_rq) begin
                        bus.rd_valid = 1'b1;
                        bus.rd_data  = (nrd < busy_reads) ? 32'h2000 : 32'h0;
                        nrd++;
                    end
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic clr();
        ntx = 0; nrd = 0; busy_cyc = 0; wr_hi = 0; both_hi = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(string tag, int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, busy, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        lat = 0; rd_lat = 0; busy_reads = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_done",  done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_code",  err_code, 2'd0);
        chk("rst_eidx",  err_index, 5'd0);
        chk("rst_rq",    {bus.wr_rq, bus.rd_rq}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        // Full table, zero-latency acks, poll matches on first read.
        clr();
        pulse_start();
        wait_idle("run1", 200);
        chk("run1_done",   done, 1'b1);
        chk("run1_error",  error, 1'b0);
        chk("run1_cycles", busy_cyc, 33);
        chk("run1_ntx",    ntx, 10);
        chk("run1_nrd",    nrd, 1);
        chk("run1_t0",     {tx_rd[0], tx_adr[0], tx_dat[0]},
                           {1'b0, 32'h008, 32'h2000});
        chk("run1_t1",     {tx_rd[1], tx_adr[1]}, {1'b1, 32'h008});
        chk("run1_t4",     {tx_adr[4], tx_dat[4]}, {32'h014, 32'd1518});
        chk("run1_t9",     {tx_rd[9], tx_adr[9], tx_dat[9]},
                           {1'b0, 32'h008, 32'h3});
        chk("run1_gap01",  rise_c[1] - ack_c[0] - 1, 1);
        chk("run1_delay",  rise_c[9] - ack_c[8] - 1, 12);
        chk("run1_wrhi",   wr_hi, 9);
        chk("run1_both",   both_hi, 0);

        // Restart from DONE, one-cycle ack latency, poll busy for 3 reads.
        lat = 1; rd_lat = 1; busy_reads = 3;
        clr();
        pulse_start();
        chk("rs_done_clr", done, 1'b0);
        chk("rs_busy",     busy, 1'b1);
        repeat (4) @(negedge clk);
        pulse_start();
        wait_idle("run2", 200);
        chk("run2_done",   done, 1'b1);
        chk("run2_error",  error, 1'b0);
        chk("run2_cycles", busy_cyc, 52);
        chk("run2_ntx",    ntx, 13);
        chk("run2_nrd",    nrd, 4);
        chk("run2_t0",     {tx_rd[0], tx_adr[0]}, {1'b0, 32'h008});
        chk("run2_both",   both_hi, 0);

        // Poll never clears: four reads then poll-exhausted error.
        lat = 0; rd_lat = 0; busy_reads = 1000;
        clr();
        pulse_start();
        wait_idle("pex", 200);
        chk("pex_error", error, 1'b1);
        chk("pex_code",  err_code, 2'd2);
        chk("pex_eidx",  err_index, 5'd1);
        chk("pex_done",  done, 1'b0);
        chk("pex_nrd",   nrd, 4);

        // No ack at all: write request held 16 cycles then timeout.
        lat = 1000; busy_reads = 0;
        clr();
        pulse_start();
        wait_idle("tmo", 100);
        chk("tmo_error", error, 1'b1);
        chk("tmo_code",  err_code, 2'd1);
        chk("tmo_eidx",  err_index, 5'd0);
        chk("tmo_done",  done, 1'b0);
        chk("tmo_wrhi",  wr_hi, 16);
        chk("tmo_ntx",   ntx, 0);
        chk("tmo_rq",    bus.wr_rq, 1'b0);

        // Reset asserted asynchronously while a read is pending.
        lat = 0; rd_lat = 1000;
        clr();
        pulse_start();
        begin
            int n = 0;
            while (!bus.rd_rq && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("ar_rdrq_seen", bus.rd_rq, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("ar_rdrq", bus.rd_rq, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_flags", {done, error}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("ar_idle", {busy, bus.wr_rq, bus.rd_rq}, 3'b000);

        // After reset the sequence runs again from entry 0.
        rd_lat = 0;
        clr();
        pulse_start();
        wait_idle("run3", 200);
        chk("run3_done", done, 1'b1);
        chk("run3_ntx",  ntx, 10);
        chk("run3_t0",   tx_adr[0], 32'h008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
